// File: rtl/noc_xbar_reg_pkg.sv
// Shared constants and types for the registered NoC crossbar.
// Optional per-output flit counters are enabled with NOC_XBAR_FLIT_CNT_EN.
package noc_pkg;
   localparam int NOC_DATA_W = 16;
   localparam int NOC_NPORTS = 5;
   localparam int NOC_SEL_W  = $clog2(NOC_NPORTS);

   localparam int PORT_N = 0;
   localparam int PORT_S = 1;
   localparam int PORT_E = 2;
   localparam int PORT_W = 3;
   localparam int PORT_L = 4;

   typedef logic [NOC_SEL_W-1:0] port_sel_t;
endpackage

// File: rtl/noc_xbar_reg_if.sv
// Crossbar-side bundle: input flits, per-output selects and output links.
// flit_cnt exists only when NOC_XBAR_FLIT_CNT_EN is defined.
interface noc_xbar_reg_if
   import noc_pkg::*;
#(
   parameter int DATA_W = NOC_DATA_W,
   parameter int NPORTS = NOC_NPORTS,
   parameter int SEL_W  = $clog2(NPORTS)
);
   logic [NPORTS*DATA_W-1:0] in_data;
   logic [NPORTS-1:0]        in_valid;
   logic [NPORTS-1:0]        in_ready;
   logic [NPORTS*SEL_W-1:0]  sel;
   logic [NPORTS-1:0]        sel_valid;
   logic [NPORTS*DATA_W-1:0] out_data;
   logic [NPORTS-1:0]        out_valid;
   logic [NPORTS-1:0]        out_ready;
   logic [NPORTS-1:0]        sel_err;
   logic                     conflict;
`ifdef NOC_XBAR_FLIT_CNT_EN
   logic [NPORTS*16-1:0]     flit_cnt;
`endif

   modport master (
      output in_data, in_valid, sel, sel_valid, out_ready,
      input  in_ready, out_data, out_valid, sel_err, conflict
`ifdef NOC_XBAR_FLIT_CNT_EN
      , input flit_cnt
`endif
   );

   modport slave (
      input  in_data, in_valid, sel, sel_valid, out_ready,
      output in_ready, out_data, out_valid, sel_err, conflict
`ifdef NOC_XBAR_FLIT_CNT_EN
      , output flit_cnt
`endif
   );
endinterface

// File: rtl/noc_xbar_reg_out_reg.sv
// One-entry valid/ready output register; load has priority over pop.
// The handshake counter is built only with NOC_XBAR_FLIT_CNT_EN.
module noc_out_reg #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              pop,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q,
   output logic              vld
`ifdef NOC_XBAR_FLIT_CNT_EN
   , output logic [15:0]     cnt
`endif
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= '0;
         vld <= 1'b0;
      end else if (load) begin
         q   <= d;
         vld <= 1'b1;
      end else if (pop) begin
         vld <= 1'b0;
      end
   end

`ifdef NOC_XBAR_FLIT_CNT_EN
   // Counts link handshakes, wrapping naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          cnt <= '0;
      else if (vld && pop) cnt <= cnt + 16'd1;
   end
`endif
endmodule

// File: rtl/noc_xbar_reg.sv
// Registered NPORTS x NPORTS crossbar with select checking and priority conflict resolution.
// Define NOC_XBAR_FLIT_CNT_EN to add per-output flit handshake counters.
module noc_xbar_reg
   import noc_pkg::*;
#(
   parameter int DATA_W = NOC_DATA_W,
   parameter int NPORTS = NOC_NPORTS,
   parameter int SEL_W  = $clog2(NPORTS)
) (
   input logic           clk,
   input logic           rst_n,
   noc_xbar_reg_if.slave bus
);
   logic [NPORTS-1:0][SEL_W-1:0]  src;
   logic [NPORTS-1:0][DATA_W-1:0] in_flit;
   logic [NPORTS-1:0][DATA_W-1:0] mux_flit;
   logic [NPORTS-1:0][DATA_W-1:0] out_flit;
   logic [NPORTS-1:0]             bad_sel;
   logic [NPORTS-1:0]             legal;
   logic [NPORTS-1:0]             win;
   logic [NPORTS-1:0]             can_load;
   logic [NPORTS-1:0]             load;
   logic [NPORTS-1:0]             rdy;
   logic [NPORTS-1:0]             out_vld;
   logic [NPORTS-1:0]             err_q;
   logic                          lost;
   logic                          conflict_q;

   assign src     = bus.sel;
   assign in_flit = bus.in_data;

   // A select is illegal when it is out of range or points back at its own port.
   always_comb begin
      bad_sel = '0;
      legal   = '0;
      for (int o = 0; o < NPORTS; o++) begin
         bad_sel[o] = bus.sel_valid[o] && ((int'(src[o]) >= NPORTS) || (int'(src[o]) == o));
         legal[o]   = bus.sel_valid[o] && !bad_sel[o];
      end
   end

   // Lowest-index output claiming an input keeps it; later claimants are dropped.
   always_comb begin
      win  = legal;
      lost = 1'b0;
      for (int o = 1; o < NPORTS; o++) begin
         for (int p = 0; p < NPORTS; p++) begin
            if (p < o && legal[o] && legal[p] && src[p] == src[o]) begin
               win[o] = 1'b0;
               lost   = 1'b1;
            end
         end
      end
   end

   assign can_load = ~out_vld | bus.out_ready;

   always_comb begin
      rdy      = '0;
      load     = '0;
      mux_flit = '0;
      for (int o = 0; o < NPORTS; o++) begin
         for (int i = 0; i < NPORTS; i++) begin
            if (win[o] && int'(src[o]) == i) begin
               mux_flit[o] = in_flit[i];
               rdy[i]      = rdy[i] | can_load[o];
               load[o]     = can_load[o] && bus.in_valid[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q      <= '0;
         conflict_q <= 1'b0;
      end else begin
         err_q      <= err_q | bad_sel;
         conflict_q <= lost;
      end
   end

`ifdef NOC_XBAR_FLIT_CNT_EN
   logic [NPORTS-1:0][15:0] cnt;
   assign bus.flit_cnt = cnt;
`endif

   for (genvar o = 0; o < NPORTS; o++) begin : g_out
      noc_out_reg #(.DATA_W(DATA_W)) u_reg (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (load[o]),
         .pop   (bus.out_ready[o]),
         .d     (mux_flit[o]),
         .q     (out_flit[o]),
         .vld   (out_vld[o])
`ifdef NOC_XBAR_FLIT_CNT_EN
         , .cnt (cnt[o])
`endif
      );
   end

   assign bus.in_ready  = rdy;
   assign bus.out_data  = out_flit;
   assign bus.out_valid = out_vld;
   assign bus.sel_err   = err_q;
   assign bus.conflict  = conflict_q;
endmodule

// File: tb/tb_noc_xbar_reg.sv
// Randomized bench for noc_xbar_reg against a first-claimant-wins port model.
// Exercises flit_cnt when NOC_XBAR_FLIT_CNT_EN is defined.
module tb_noc_xbar_reg;
   localparam int N = 5;
   localparam int W = 16;
   localparam int S = 3;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   noc_xbar_reg_if #(.DATA_W(W), .NPORTS(N), .SEL_W(S)) bus ();
   noc_xbar_reg #(.DATA_W(W), .NPORTS(N), .SEL_W(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // model state: one slot per output link
   logic [W-1:0]  md   [N];
   logic          mv   [N];
   logic          merr [N];
   logic [15:0]   mcnt [N];
   logic          mconf;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   always @(negedge clk) begin : cmp
      logic [N*W-1:0]  ed;
      logic [N*16-1:0] ec;
      logic [N-1:0]    ev, ee, er;
      logic            claimed [N];
      logic            has     [N];
      logic            ill     [N];
      int              src     [N];
      logic            conf;
      int              s;
      for (int o = 0; o < N; o++) begin
         ed[o*W +: W]   = rst_n ? md[o] : '0;
         ev[o]          = rst_n ? mv[o] : 1'b0;
         ee[o]          = rst_n ? merr[o] : 1'b0;
         ec[o*16 +: 16] = rst_n ? mcnt[o] : '0;
      end
      chk("out_valid", {123'd0, bus.out_valid}, {123'd0, ev});
      chk("out_data", {48'd0, bus.out_data}, {48'd0, ed});
      chk("sel_err", {123'd0, bus.sel_err}, {123'd0, ee});
      chk("conflict", {127'd0, bus.conflict}, {127'd0, rst_n ? mconf : 1'b0});
`ifdef NOC_XBAR_FLIT_CNT_EN
      chk("flit_cnt", {48'd0, bus.flit_cnt}, {48'd0, ec});
`endif
      conf = 1'b0;
      er   = '0;
      for (int o = 0; o < N; o++) begin
         claimed[o] = 1'b0; has[o] = 1'b0; ill[o] = 1'b0; src[o] = 0;
      end
      for (int o = 0; o < N; o++) begin
         if (bus.sel_valid[o]) begin
            s = int'(bus.sel[o*S +: S]);
            if (s >= N || s == o) ill[o] = 1'b1;
            else if (claimed[s])  conf = 1'b1;
            else begin
               claimed[s] = 1'b1; has[o] = 1'b1; src[o] = s;
            end
         end
      end
      for (int o = 0; o < N; o++)
         if (has[o] && (!ev[o] || bus.out_ready[o])) er[src[o]] = 1'b1;
      chk("in_ready", {123'd0, bus.in_ready}, {123'd0, er});
      if (!rst_n) begin
         for (int o = 0; o < N; o++) begin
            md[o] <= '0; mv[o] <= 1'b0; merr[o] <= 1'b0; mcnt[o] <= '0;
         end
         mconf <= 1'b0;
      end else begin
         for (int o = 0; o < N; o++) begin
            if (ev[o] && bus.out_ready[o]) mcnt[o] <= ec[o*16 +: 16] + 16'd1;
            if (has[o] && er[src[o]] && bus.in_valid[src[o]]) begin
               md[o] <= bus.in_data[src[o]*W +: W];
               mv[o] <= 1'b1;
            end else if (bus.out_ready[o]) begin
               mv[o] <= 1'b0;
            end
            if (ill[o]) merr[o] <= 1'b1;
         end
         mconf <= conf;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_data   = '0;
      bus.in_valid  = '0;
      bus.sel       = '0;
      bus.sel_valid = '0;
      bus.out_ready = '1;
   endtask

   task automatic set_sel(input int o, input int s);
      bus.sel[o*S +: S]  = S'(s);
      bus.sel_valid[o]   = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (3) cyc();
      chk("rst_out_valid", {123'd0, bus.out_valid}, 128'd0);
      chk("rst_out_data", {48'd0, bus.out_data}, 128'd0);
      chk("rst_sel_err", {123'd0, bus.sel_err}, 128'd0);
      chk("rst_in_ready", {123'd0, bus.in_ready}, 128'd0);
      rst_n = 1'b1;
      cyc();
      chk("rel_conflict", {127'd0, bus.conflict}, 128'd0);
      chk("rel_out_valid", {123'd0, bus.out_valid}, 128'd0);

      // L -> N single flit
      bus.in_data[4*W +: W] = 16'hA5A5; bus.in_valid[4] = 1'b1; set_sel(0, 4);
      #1 chk("a5_in_ready_L", {127'd0, bus.in_ready[4]}, 128'd1);
      cyc();
      chk("a5_data_N", {112'd0, bus.out_data[0 +: W]}, 128'h0A5A5);
      chk("a5_valid_N", {127'd0, bus.out_valid[0]}, 128'd1);
      idle(); cyc(); cyc();

      // W -> E under back-pressure
      bus.out_ready[2] = 1'b0; set_sel(2, 3); bus.in_valid[3] = 1'b1; bus.in_data[3*W +: W] = 16'd1;
      cyc();
      chk("bp_first", {112'd0, bus.out_data[2*W +: W]}, 128'd1);
      bus.in_data[3*W +: W] = 16'd2;
      #1 chk("bp_stall_ready", {127'd0, bus.in_ready[3]}, 128'd0);
      cyc(); cyc();
      chk("bp_hold", {112'd0, bus.out_data[2*W +: W]}, 128'd1);
      chk("bp_hold_valid", {127'd0, bus.out_valid[2]}, 128'd1);
      bus.out_ready[2] = 1'b1;
      #1 chk("bp_release_ready", {127'd0, bus.in_ready[3]}, 128'd1);
      cyc();
      chk("bp_second", {112'd0, bus.out_data[2*W +: W]}, 128'd2);
      bus.in_data[3*W +: W] = 16'd3;
      cyc();
      chk("bp_third", {112'd0, bus.out_data[2*W +: W]}, 128'd3);
      bus.in_valid[3] = 1'b0;
      cyc();
      chk("bp_drain_valid", {127'd0, bus.out_valid[2]}, 128'd0);
      chk("bp_drain_data", {112'd0, bus.out_data[2*W +: W]}, 128'd3);
      idle(); cyc();

      // N and E both want L
      set_sel(0, 4); set_sel(2, 4); bus.in_valid[4] = 1'b1; bus.in_data[4*W +: W] = 16'h1234;
      cyc();
      chk("cf_valid_N", {127'd0, bus.out_valid[0]}, 128'd1);
      chk("cf_valid_E", {127'd0, bus.out_valid[2]}, 128'd0);
      chk("cf_data_N", {112'd0, bus.out_data[0 +: W]}, 128'h1234);
      chk("cf_pulse", {127'd0, bus.conflict}, 128'd1);
      idle(); cyc();
      chk("cf_clear", {127'd0, bus.conflict}, 128'd0);
      cyc();

      // U-turn on S, out-of-range on W
      set_sel(1, 1); set_sel(3, 7); bus.in_valid = '1;
      cyc();
      chk("ill_err", {123'd0, bus.sel_err}, 128'b01010);
      chk("ill_no_xfer", {123'd0, bus.out_valid}, 128'd0);
      idle(); cyc();
      chk("ill_sticky", {123'd0, bus.sel_err}, 128'b01010);

      // random traffic
      for (int k = 0; k < 2000; k++) begin
         for (int p = 0; p < N; p++) begin
            bus.in_data[p*W +: W] = W'($urandom);
            bus.in_valid[p]       = ($urandom_range(0, 3) != 0);
            bus.sel[p*S +: S]     = S'($urandom_range(0, 7));
            bus.sel_valid[p]      = ($urandom_range(0, 3) != 0);
            bus.out_ready[p]      = ($urandom_range(0, 9) < 7);
         end
         cyc();
      end
      idle();
      rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();

`ifdef NOC_XBAR_FLIT_CNT_EN
      set_sel(4, 0); bus.in_valid[0] = 1'b1;
      repeat (65538) cyc();
      chk("cnt_wrap_L", {112'd0, bus.flit_cnt[4*16 +: 16]}, 128'd1);
`else
      set_sel(4, 0); bus.in_valid[0] = 1'b1; bus.in_data[0 +: W] = 16'h0BEE;
      repeat (4) cyc();
`endif
      // reset in the middle of a stream
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {123'd0, bus.out_valid}, 128'd0);
      chk("mid_rst_data", {48'd0, bus.out_data}, 128'd0);
`ifdef NOC_XBAR_FLIT_CNT_EN
      chk("mid_rst_cnt", {48'd0, bus.flit_cnt}, 128'd0);
`endif
      idle(); cyc();
      rst_n = 1'b1;
      cyc(); cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
